// File: rtl/quadra_arb_pkg.sv
// Shared quadra types plus the arbiter-specific tag type and default sizes.
// Every quadra_arb file imports this package.
package quadra_arb_pkg;

   localparam int X_W = 24;
   localparam int Y_W = 32;

   typedef logic [X_W-1:0] x_t;
   typedef logic [Y_W-1:0] y_t;
   typedef logic           ck_t;
   typedef logic           rs_t;

   localparam int N_REQ_DEF = 4;
   localparam int LAT_DEF   = 3;

   // Tag width for n requesters; never narrower than one bit.
   function automatic int tag_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int TAG_W = tag_w(N_REQ_DEF);
   typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the search starts one past last_grant and wraps,
// so the grant is one-hot and all zero when nothing is requested.
module rr_arbiter
   import quadra_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int TW    = tag_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [TW-1:0]    last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [TW-1:0]    grant_idx
);

   logic          found;
   logic [TW-1:0] pos;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos = TW'((int'(last_grant) + k) % N_REQ);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            grant_idx  = pos;
         end
      end
   end

endmodule

// File: rtl/quadra_arb.sv
// Shares one quadra among N_REQ requesters: round-robin issue, one accept per
// cycle, and an LAT-deep valid/tag pipeline that routes each result back in order.
module quadra_arb
   import quadra_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int LAT   = LAT_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req_valid,
   input  x_t [N_REQ-1:0]   req_x,
   output logic [N_REQ-1:0] req_ready,
   output x_t               q_x,
   output logic             q_rst_b,
   input  y_t               q_y,
   output logic [N_REQ-1:0] rsp_valid,
   output y_t               rsp_y,
   output logic             busy,
   output logic [CNT_W-1:0] issued
);

   localparam int TW = tag_w(N_REQ);

   logic [N_REQ-1:0] req_eff;
   logic [N_REQ-1:0] grant;
   logic [TW-1:0]    grant_idx;
   logic             accept;

   logic [TW-1:0]    last_q;
   logic [LAT-1:0]   vld_q;
   logic [TW-1:0]    tag_q [LAT];
   logic [N_REQ-1:0] rsp_valid_q;
   logic [N_REQ-1:0] rsp_valid_d;
   y_t               rsp_y_q;
   logic [CNT_W-1:0] issued_q;

   // Gating the requests (not the grant) keeps en from touching in-flight work.
   assign req_eff = en ? req_valid : '0;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .TW    (TW)
   ) u_rr (
      .req        (req_eff),
      .last_grant (last_q),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   assign accept    = |grant;
   assign req_ready = grant;
   assign q_x       = accept ? req_x[grant_idx] : '0;
   assign q_rst_b   = ~rst;

   always_comb begin
      rsp_valid_d = '0;
      if (vld_q[LAT-1]) begin
         rsp_valid_d[tag_q[LAT-1]] = 1'b1;
      end
   end

   // Stage i holds the accept from i edges ago; the last stage lines up with a stable q_y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q      <= TW'(N_REQ - 1);
         vld_q       <= '0;
         for (int k = 0; k < LAT; k++) begin
            tag_q[k] <= '0;
         end
         rsp_valid_q <= '0;
         rsp_y_q     <= '0;
         issued_q    <= '0;
      end else begin
         if (accept) begin
            last_q   <= grant_idx;
            issued_q <= issued_q + 1'b1;
         end
         vld_q[0] <= accept;
         tag_q[0] <= accept ? grant_idx : '0;
         for (int k = 1; k < LAT; k++) begin
            vld_q[k] <= vld_q[k-1];
            tag_q[k] <= tag_q[k-1];
         end
         rsp_valid_q <= rsp_valid_d;
         if (vld_q[LAT-1]) begin
            rsp_y_q <= q_y;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_y     = rsp_y_q;
   assign busy      = (|vld_q) | (|rsp_valid_q);
   assign issued    = issued_q;

endmodule

// File: tb/tb_quadra_arb.sv
// Directed bench for quadra_arb with a behavioural quadra (y = x*x + 1, LAT stages).
module tb_quadra_arb;
   import quadra_arb_pkg::*;

   localparam int N  = 4;
   localparam int L  = 3;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [N-1:0]  req_valid = '0;
   x_t [N-1:0]    req_x = '0;
   logic [N-1:0]  req_ready;
   x_t            q_x;
   logic          q_rst_b;
   y_t            q_y;
   logic [N-1:0]  rsp_valid;
   y_t            rsp_y;
   logic          busy;
   logic [CW-1:0] issued;

   int n_chk  = 0;
   int n_pass = 0;

   x_t xv [N] = '{24'h000001, 24'h123456, 24'hABCDEF, 24'h7FFFFF};
   y_t qp [L];

   quadra_arb #(.N_REQ(N), .LAT(L), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .q_x       (q_x),
      .q_rst_b   (q_rst_b),
      .q_y       (q_y),
      .rsp_valid (rsp_valid),
      .rsp_y     (rsp_y),
      .busy      (busy),
      .issued    (issued)
   );

   always #5 clk = ~clk;

   function automatic y_t f(input x_t x);
      logic [47:0] p;
      p = {24'h0, x} * {24'h0, x};
      return p[31:0] + 32'd1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Quadra stand-in: samples x on an edge, result appears at the last stage.
   always @(posedge clk or negedge q_rst_b) begin
      if (!q_rst_b) begin
         for (int i = 0; i < L; i++) qp[i] <= '0;
      end else begin
         qp[0] <= f(q_x);
         for (int i = 1; i < L; i++) qp[i] <= qp[i-1];
      end
   end
   assign q_y = qp[L-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
         $display("%-12s got=%0h exp=%0h ok", tag, got, exp);
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0] e_rsp;
      logic [N-1:0] e_rdy;
      logic [N-1:0] seq5 [3];
      seq5[0] = 4'b1000;
      seq5[1] = 4'b0010;
      seq5[2] = 4'b1000;

      for (int i = 0; i < N; i++) req_x[i] = xv[i];

      // Reset state, checked before any clock edge.
      #2;
      chk("rst_busy", 64'(busy), 64'(1'b0));
      chk("rst_issued", 64'(issued), 64'(16'h0));
      chk("rst_rspv", 64'(rsp_valid), 64'(4'h0));
      chk("rst_rspy", 64'(rsp_y), 64'(32'h0));
      chk("rst_qrstb", 64'(q_rst_b), 64'(1'b0));
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rel_qrstb", 64'(q_rst_b), 64'(1'b1));

      // All four requesting: rotating grants, ordered responses.
      en = 1'b1;
      for (int j = 0; j < 13; j++) begin
         req_valid = (j < 8) ? 4'hF : 4'h0;
         #1;
         e_rdy = (j < 8) ? onehot(j % 4) : 4'h0;
         chk($sformatf("t1_rdy%0d", j), 64'(req_ready), 64'(e_rdy));
         if (j < 8) chk($sformatf("t1_qx%0d", j), 64'(q_x), 64'(xv[j % 4]));
         e_rsp = (j >= 4 && j < 12) ? onehot((j - 4) % 4) : 4'h0;
         chk($sformatf("t1_rsp%0d", j), 64'(rsp_valid), 64'(e_rsp));
         if (j >= 4 && j < 12) chk($sformatf("t1_y%0d", j), 64'(rsp_y), 64'(f(xv[(j - 4) % 4])));
         chk($sformatf("t1_busy%0d", j), 64'(busy), 64'(j >= 1 && j <= 11));
         step();
      end
      chk("t1_issued", 64'(issued), 64'(16'd8));

      // Requester 2 only, extreme operands back to back.
      for (int j = 0; j < 7; j++) begin
         if (j == 0) req_x[2] = 24'h000000;
         if (j == 1) req_x[2] = 24'hFFFFFF;
         req_valid = (j < 2) ? 4'b0100 : 4'b0000;
         #1;
         chk($sformatf("t2_rdy%0d", j), 64'(req_ready), 64'((j < 2) ? 4'b0100 : 4'b0000));
         if (j < 2) chk($sformatf("t2_qx%0d", j), 64'(q_x), 64'(req_x[2]));
         chk($sformatf("t2_rsp%0d", j), 64'(rsp_valid), 64'((j == 4 || j == 5) ? 4'b0100 : 4'b0000));
         if (j == 4) chk("t2_y0", 64'(rsp_y), 64'(32'h00000001));
         if (j >= 5) chk($sformatf("t2_y%0d", j), 64'(rsp_y), 64'(32'hFE000002));
         step();
      end
      req_x[2] = xv[2];

      // Four accepts, then en low: no grants, in-flight work still responds.
      for (int j = 0; j < 9; j++) begin
         en = (j < 4);
         req_valid = 4'hF;
         #1;
         e_rdy = (j < 4) ? onehot((3 + j) % 4) : 4'h0;
         chk($sformatf("t3_rdy%0d", j), 64'(req_ready), 64'(e_rdy));
         e_rsp = (j >= 4 && j < 8) ? onehot((3 + j - 4) % 4) : 4'h0;
         chk($sformatf("t3_rsp%0d", j), 64'(rsp_valid), 64'(e_rsp));
         chk($sformatf("t3_busy%0d", j), 64'(busy), 64'(j >= 1 && j <= 7));
         step();
      end
      en = 1'b1;
      req_valid = 4'h0;
      chk("t3_issued", 64'(issued), 64'(16'd14));

      // Reset with three operations in flight.
      for (int j = 0; j < 3; j++) begin
         req_valid = 4'hF;
         #1;
         chk($sformatf("t4_rdy%0d", j), 64'(req_ready), 64'(onehot((3 + j) % 4)));
         step();
      end
      req_valid = 4'h0;
      #1;
      rst = 1'b1;
      #1;
      chk("t4_busy", 64'(busy), 64'(1'b0));
      chk("t4_issued", 64'(issued), 64'(16'h0));
      chk("t4_rspv", 64'(rsp_valid), 64'(4'h0));
      step();
      rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
         #1;
         chk($sformatf("t4_quiet%0d", j), 64'(rsp_valid), 64'(4'h0));
         step();
      end
      req_valid = 4'hF;
      #1;
      chk("t4_first", 64'(req_ready), 64'(4'b0001));
      step();
      req_valid = 4'h0;
      chk("t4_iss1", 64'(issued), 64'(16'd1));
      for (int j = 0; j < 4; j++) begin
         #1;
         chk($sformatf("t4_rsp%0d", j), 64'(rsp_valid), 64'((j == 3) ? 4'b0001 : 4'b0000));
         if (j == 3) chk("t4_y", 64'(rsp_y), 64'(f(xv[0])));
         step();
      end

      // Set last_grant to 1, then alternate between requesters 3 and 1.
      req_valid = 4'b0010;
      #1;
      chk("t5_pre", 64'(req_ready), 64'(4'b0010));
      step();
      for (int j = 0; j < 3; j++) begin
         req_valid = 4'b1010;
         #1;
         chk($sformatf("t5_rdy%0d", j), 64'(req_ready), 64'(seq5[j]));
         step();
      end
      req_valid = 4'h0;
      repeat (5) step();

      // Counter wrap after 2^16 accepts.
      rst = 1'b1;
      #1;
      step();
      rst = 1'b0;
      req_valid = 4'b0001;
      repeat (65535) step();
      chk("t6_full", 64'(issued), 64'(16'hFFFF));
      step();
      chk("t6_wrap", 64'(issued), 64'(16'h0000));
      req_valid = 4'h0;
      repeat (5) step();
      chk("t6_idle", 64'(busy), 64'(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
